hazard_ctrl: RTL and testbench

//  Pipeline hazard controller for the 5-stage MIPS core. Watches the ID-stage operands and the
//  EX/MEM stage state, then drives the pipeline-register control inputs:
//  - PC / IF_ID write-enable.
//  - ID_EX bubble insertion (zeroes the control fields latched into ID_EX).
//  - IF_ID / ID_EX / EX_MEM flushes on a taken branch.

---
 rtl/hazard_ctrl.sv | 81 ++++++++
 tb/tb_hazard_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall and taken-branch flush control for the 5-stage pipeline.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall/flush performance counters.
module hazard_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_UsesRt,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_rt,
    input  logic             MEM_BranchTaken,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             ID_EX_Bubble,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Flush
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
`endif
);
    typedef enum logic {RUN, STALL} state_t;
    localparam logic [3:0] CNT_LOAD = 4'(LOAD_STALL_CYCLES - 1);
    localparam bit MULTI = LOAD_STALL_CYCLES > 1;
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       haz, stall, flush;
    // Outputs are Mealy on (state, inputs); reset forces free-running, flush beats stall
    always_comb begin
        haz          = EX_MemRead && EX_rt != 5'd0 && (EX_rt == ID_rs || (ID_UsesRt && EX_rt == ID_rt));
        flush        = !rst && MEM_BranchTaken;
        stall        = !rst && !MEM_BranchTaken && (state_q == STALL || haz);
        PCWrite      = !stall;
        IF_ID_Write  = !stall;
        ID_EX_Bubble = stall;
        IF_ID_Flush  = flush;
        ID_EX_Flush  = flush;
        EX_MEM_Flush = flush;
        state_d      = MEM_BranchTaken ? RUN :
                       state_q == STALL ? (cnt_q == 4'd1 ? RUN : STALL) :
                       (haz && MULTI) ? STALL : RUN;
        cnt_d        = MEM_BranchTaken ? 4'd0 :
                       state_q == STALL ? cnt_q - 4'd1 :
                       (haz && MULTI) ? CNT_LOAD : 4'd0;
    end
    // State and remaining-stall counter; async reset abandons any stall in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_count_q, stall_count_d, flush_count_q, flush_count_d;
    // Saturating event counters: bubble cycles and taken-branch cycles
    always_comb begin
        stall_count_d = (ID_EX_Bubble && !(&stall_count_q)) ? stall_count_q + CNT_W'(1) : stall_count_q;
        flush_count_d = (MEM_BranchTaken && !(&flush_count_q)) ? flush_count_q + CNT_W'(1) : flush_count_q;
    end
    // Counter registers, cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end
    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed plus random checks of hazard_ctrl (N=1 and N=3) against a stall-budget model.
module tb_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
    logic       uses_rt = 1'b0, mem_read = 1'b0, br = 1'b0;
    wire  [5:0] o1, o3;
    int         vectors = 0, miscompares = 0;
    int         rem1 = 0, rem3 = 0;
    int         sc1m = 0, fc1m = 0, sc3m = 0, fc3m = 0;
`ifdef HAZARD_PERF_CNT_EN
    wire  [1:0] sc1, fc1, sc3, fc3;
`endif

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(2)) u1 (
        .clk(clk), .rst(rst), .ID_rs(id_rs), .ID_rt(id_rt), .ID_UsesRt(uses_rt),
        .EX_MemRead(mem_read), .EX_rt(ex_rt), .MEM_BranchTaken(br),
        .PCWrite(o1[5]), .IF_ID_Write(o1[4]), .ID_EX_Bubble(o1[3]),
        .IF_ID_Flush(o1[2]), .ID_EX_Flush(o1[1]), .EX_MEM_Flush(o1[0])
`ifdef HAZARD_PERF_CNT_EN
        , .stall_count(sc1), .flush_count(fc1)
`endif
    );

    hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(2)) u3 (
        .clk(clk), .rst(rst), .ID_rs(id_rs), .ID_rt(id_rt), .ID_UsesRt(uses_rt),
        .EX_MemRead(mem_read), .EX_rt(ex_rt), .MEM_BranchTaken(br),
        .PCWrite(o3[5]), .IF_ID_Write(o3[4]), .ID_EX_Bubble(o3[3]),
        .IF_ID_Flush(o3[2]), .ID_EX_Flush(o3[1]), .EX_MEM_Flush(o3[0])
`ifdef HAZARD_PERF_CNT_EN
        , .stall_count(sc3), .flush_count(fc3)
`endif
    );

    function automatic logic hazard();
        return mem_read && ex_rt != 0 && (ex_rt == id_rs || (uses_rt && ex_rt == id_rt));
    endfunction

    // {PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush}
    function automatic logic [5:0] expv(input int rem);
        if (rst) return 6'b110000;
        if (br) return 6'b110111;
        if (rem > 0 || hazard()) return 6'b001000;
        return 6'b110000;
    endfunction

    function automatic int next_rem(input int rem, input int n);
        if (rst || br) return 0;
        if (rem > 0) return rem - 1;
        if (hazard()) return n - 1;
        return 0;
    endfunction

    function automatic int sat3(input int v);
        return v > 3 ? 3 : v;
    endfunction

    task automatic chk(input string tag);
        logic [5:0] e1, e3;
        e1 = expv(rem1);
        e3 = expv(rem3);
        vectors++;
        assert (o1 === e1) else begin
            miscompares++;
            $error("FAIL %s N1 outputs got %b want %b", tag, o1, e1);
        end
        vectors++;
        assert (o3 === e3) else begin
            miscompares++;
            $error("FAIL %s N3 outputs got %b want %b", tag, o3, e3);
        end
`ifdef HAZARD_PERF_CNT_EN
        vectors++;
        assert ({sc1, fc1, sc3, fc3} === {2'(sc1m), 2'(fc1m), 2'(sc3m), 2'(fc3m)}) else begin
            miscompares++;
            $error("FAIL %s perf got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", tag,
                   sc1, fc1, sc3, fc3, sc1m, fc1m, sc3m, fc3m);
        end
`endif
    endtask

    task automatic advance();
        logic [5:0] e1, e3;
        e1 = expv(rem1);
        e3 = expv(rem3);
        sc1m = rst ? 0 : sat3(sc1m + int'(e1[3]));
        sc3m = rst ? 0 : sat3(sc3m + int'(e3[3]));
        fc1m = rst ? 0 : sat3(fc1m + int'(br));
        fc3m = rst ? 0 : sat3(fc3m + int'(br));
        rem1 = next_rem(rem1, 1);
        rem3 = next_rem(rem3, 3);
    endtask

    task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                        input logic mr, input logic [4:0] ert, input logic b, input string tag);
        @(negedge clk);
        rst = r; id_rs = rs; id_rt = rt; uses_rt = ur; mem_read = mr; ex_rt = ert; br = b;
        #1;
        chk(tag);
        advance();
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0, 0, "reset");
        step(1, 5, 5, 1, 1, 5, 0, "reset_masks_haz");
        step(0, 0, 0, 0, 0, 0, 0, "idle");
        step(0, 5, 2, 1, 1, 5, 0, "lw_use_rs");
        step(0, 5, 2, 1, 0, 0, 0, "after_lw");
        step(0, 3, 3, 1, 0, 0, 0, "run");
        step(0, 0, 0, 1, 1, 0, 0, "r0_no_haz");
        step(0, 1, 7, 0, 1, 7, 0, "rt_unused");
        step(0, 1, 7, 1, 1, 7, 0, "rt_used");
        step(0, 1, 7, 1, 0, 0, 0, "stall2");
        step(0, 1, 7, 1, 0, 0, 0, "stall3");
        step(0, 1, 7, 1, 0, 0, 0, "back_run");
        step(0, 9, 9, 1, 1, 9, 0, "same_reg");
        step(0, 9, 9, 1, 0, 0, 1, "branch_in_stall");
        step(0, 9, 9, 1, 0, 0, 0, "run_after_flush");
        step(0, 4, 6, 1, 1, 4, 1, "flush_beats_haz");
        step(0, 4, 6, 1, 0, 0, 0, "run2");
        step(0, 2, 6, 1, 1, 2, 0, "haz_before_rst");
        step(0, 2, 6, 1, 0, 0, 0, "mid_stall");
        #2 rst = 1'b1;
        #1 chk("async_rst");
        advance();
        step(0, 0, 0, 0, 0, 0, 0, "after_rst");
        for (int i = 0; i < 6; i++)
            step(0, 8, 1, 0, 1, 8, 0, "sat_stall");
        step(0, 0, 0, 0, 0, 0, 1, "sat_branch");
        step(0, 0, 0, 0, 0, 0, 0, "sat_check");
        for (int i = 0; i < 500; i++)
            step($urandom_range(0, 63) == 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                 $urandom_range(0, 9) == 0, "random");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
